// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding a one-entry valid/ready holding register.
// Optional: define UART_RX_PARITY_EN for an even-parity bit and the parity_err_o pulse.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
`ifdef UART_RX_PARITY_EN
    localparam int BW           = 4;
    localparam int LAST_BIT     = 8;
`else
    localparam int BW           = 3;
    localparam int LAST_BIT     = 7;
`endif
    localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_IDX_LAST = BW'(LAST_BIT);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_t;

    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    logic          rx_meta_r;
    logic          rxs_r;
    logic [1:0]    sync_fill_r;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [BW-1:0] bit_idx_r;
    logic [BW-1:0] bit_idx_nxt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_nxt_s;
    logic          par_bit_r;
    logic          par_bit_nxt_s;
    logic          complete_s;
    logic          frame_err_s;
    logic [7:0]    data_r;
    logic          valid_r;
    logic          frame_err_r;
    logic          overrun_r;
    logic          parity_err_r;

    // Two-flop synchronizer; sync_fill_r marks when rxs_r reflects the real line.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rx_meta_r   <= 1'b1;
            rxs_r       <= 1'b1;
            sync_fill_r <= 2'b00;
        end else begin
            rx_meta_r   <= rx_i;
            rxs_r       <= rx_meta_r;
            sync_fill_r <= {sync_fill_r[0], 1'b1};
        end
    end

    // Frame FSM and datapath state register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r   <= ST_WAIT_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= {BW{1'b0}};
            shift_r   <= 8'h00;
            par_bit_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            par_bit_r <= par_bit_nxt_s;
        end
    end

    // Next-state logic: mid-bit sampling driven by the clock counter.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r + CW'(1);
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        par_bit_nxt_s = par_bit_r;
        complete_s    = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            ST_WAIT_IDLE: begin
                // Reset values of the synchronizer are not a genuine idle level.
                cnt_nxt_s = {CW{1'b0}};
                if (rxs_r && sync_fill_r[1]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_nxt_s     = {CW{1'b0}};
                bit_idx_nxt_s = {BW{1'b0}};
                if (!rxs_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s     = {CW{1'b0}};
                    bit_idx_nxt_s = {BW{1'b0}};
                    if (rxs_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s     = {CW{1'b0}};
                    bit_idx_nxt_s = bit_idx_r + BW'(1);
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_r == BIT_IDX_LAST) begin
                        par_bit_nxt_s = rxs_r;
                    end else begin
                        shift_nxt_s = {rxs_r, shift_r[7:1]};
                    end
`else
                    shift_nxt_s = {rxs_r, shift_r[7:1]};
`endif
                    if (bit_idx_r == BIT_IDX_LAST) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s = {CW{1'b0}};
                    if (rxs_r) begin
                        complete_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_nxt_s = ST_WAIT_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                cnt_nxt_s   = {CW{1'b0}};
                state_nxt_s = ST_WAIT_IDLE;
            end
        endcase
    end

    // Holding register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            data_r       <= 8'h00;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            frame_err_r  <= frame_err_s;
            parity_err_r <= complete_s && parity_bad(shift_r, par_bit_r);
            overrun_r    <= 1'b0;
            if (complete_s) begin
                if (!valid_r || ready_i) begin
                    data_r  <= shift_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_r;
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_err_r ^ par_bit_r ^ par_bit_nxt_s;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames plus hand-written
// sequences for holding, overrun, back-to-back, reset mid-frame and parity.
module tb_uart_rx;

    localparam int CPB = 12000000 / 115200;

    logic       clk;
    logic       reset_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    uart_rx dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         n_acc   = 0;
    int         n_vrise = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    int         n_perr  = 0;
    logic [7:0] last_acc = 8'h00;
    logic [7:0] prev_acc = 8'h00;
    logic       valid_q  = 1'b0;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_o;
            if (valid_o && !valid_q) n_vrise <= n_vrise + 1;
            if (valid_o && ready_i) begin
                n_acc    <= n_acc + 1;
                prev_acc <= last_acc;
                last_acc <= data_o;
            end
            if (frame_err_o) n_ferr <= n_ferr + 1;
            if (overrun_o) n_ovr <= n_ovr + 1;
`ifdef UART_RX_PARITY_EN
            if (parity_err_o) n_perr <= n_perr + 1;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(~(^d));
        drive_bit(1'b1);
    endtask
`endif

    typedef struct {
        int         glitch;     // >0: pull line low this many clocks instead of a frame
        logic [7:0] data;
        logic       stop;
        int         low_after;  // clocks to hold line low after the frame
        int         exp_acc;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int a0, f0, o0, p0, v0;

        vecs[0] = '{20, 8'h00, 1'b1, 0,   0, 0, 8'h00};
        vecs[1] = '{0,  8'h3C, 1'b1, 0,   1, 0, 8'h3C};
        vecs[2] = '{0,  8'h55, 1'b0, 300, 0, 1, 8'h3C};
        vecs[3] = '{0,  8'h0F, 1'b1, 0,   1, 0, 8'h0F};
        vecs[4] = '{0,  8'hA5, 1'b1, 0,   1, 0, 8'hA5};
        vecs[5] = '{0,  8'h81, 1'b1, 0,   1, 0, 8'h81};

        reset_i = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_data",  32'(data_o), 32'h00);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_ferr",  32'(frame_err_o), 32'h0);
        check("reset_ovr",   32'(overrun_o), 32'h0);
        reset_i = 1'b0;
        idle(10);

        // Table of single frames with the consumer always ready
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a0 = n_acc; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
            if (vecs[k].glitch > 0) begin
                rx_i = 1'b0;
                repeat (vecs[k].glitch) @(posedge clk);
                #1;
            end else begin
                send_frame(vecs[k].data, vecs[k].stop);
                rx_i = vecs[k].stop;
                repeat (vecs[k].low_after) @(posedge clk);
                #1;
            end
            idle(2 * CPB);
            check($sformatf("vec%0d_acc", k),  32'(n_acc - a0), 32'(vecs[k].exp_acc));
            check($sformatf("vec%0d_ferr", k), 32'(n_ferr - f0), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d_ovr", k),  32'(n_ovr - o0), 32'h0);
            check($sformatf("vec%0d_data", k), 32'(data_o), 32'(vecs[k].exp_data));
`ifdef UART_RX_PARITY_EN
            check($sformatf("vec%0d_perr", k), 32'(n_perr - p0), 32'h0);
`endif
        end

        // Byte held for 1000 cycles, then a single-cycle accept
        ready_i = 1'b0;
        a0 = n_acc;
        send_frame(8'hA5, 1'b1);
        idle(10);
        check("hold_valid0", 32'(valid_o), 32'h1);
        check("hold_data0",  32'(data_o), 32'hA5);
        idle(1000);
        check("hold_valid1", 32'(valid_o), 32'h1);
        check("hold_data1",  32'(data_o), 32'hA5);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        @(negedge clk);
        check("hold_release", 32'(valid_o), 32'h0);
        check("hold_acc",     32'(n_acc - a0), 32'h1);
        idle(5);

        // Overrun: second byte dropped while the first is still held
        a0 = n_acc; o0 = n_ovr;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2 * CPB);
        check("ovr_pulse", 32'(n_ovr - o0), 32'h1);
        check("ovr_data",  32'(data_o), 32'h11);
        check("ovr_valid", 32'(valid_o), 32'h1);
        ready_i = 1'b1;
        idle(5);
        @(negedge clk);
        check("ovr_acc",   32'(n_acc - a0), 32'h1);
        check("ovr_empty", 32'(valid_o), 32'h0);
        check("ovr_last",  32'(last_acc), 32'h11);

        // Back-to-back frames with zero idle gap
        v0 = n_vrise;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2 * CPB);
        check("b2b_vrise", 32'(n_vrise - v0), 32'h2);
        check("b2b_first", 32'(prev_acc), 32'h00);
        check("b2b_second", 32'(last_acc), 32'hFF);

        // Reset during bit 4 of 0x81 with a byte pending
        ready_i = 1'b0;
        send_frame(8'h99, 1'b1);
        idle(10);
        check("rst_pending", 32'(valid_o), 32'h1);
        a0 = n_acc; f0 = n_ferr; o0 = n_ovr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
        rx_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        repeat (CPB - 33) @(posedge clk);
        #1;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        idle(3 * CPB);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_data",  32'(data_o), 32'h00);
        check("rst_acc",   32'(n_acc - a0), 32'h0);
        check("rst_ferr",  32'(n_ferr - f0), 32'h0);
        check("rst_ovr",   32'(n_ovr - o0), 32'h0);
        ready_i = 1'b1;
        a0 = n_acc;
        send_frame(8'h7E, 1'b1);
        idle(2 * CPB);
        check("rst_next_acc",  32'(n_acc - a0), 32'h1);
        check("rst_next_data", 32'(last_acc), 32'h7E);

`ifdef UART_RX_PARITY_EN
        // Wrong parity still delivers the byte with one parity pulse
        a0 = n_acc; p0 = n_perr;
        send_bad_parity(8'hA5);
        idle(2 * CPB);
        check("par_acc",  32'(n_acc - a0), 32'h1);
        check("par_data", 32'(last_acc), 32'hA5);
        check("par_perr", 32'(n_perr - p0), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
